// File: rtl/pipe_stage_idex_multi_pkg.sv
// Shared constants and helpers for the multi-lane ID/EX pipeline register.
// Lane register operations are ordered by priority: hold, clear, load.
package pipe_stage_idex_multi_pkg;

    localparam int IDEX_LANES_MAX      = 8;
    localparam int INSTR_WIDTH         = 32;
    localparam int STAGE_WIDTH_DEFAULT = INSTR_WIDTH;

    typedef enum logic [1:0] {
        LANE_HOLD,
        LANE_CLEAR,
        LANE_LOAD
    } lane_op_e;

    // A single-lane path still needs a 1-bit beat counter port.
    function automatic int beat_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_idex_multi_lane_reg.sv
// One lane of the ID/EX register: payload plus valid.
// Async active-low reset; hold has priority over clear, clear over load.
module pipe_lane_reg
    import pipe_stage_idex_multi_pkg::*;
#(
    parameter int WIDTH = STAGE_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    lane_op_e op;

    always_comb begin
        op = LANE_HOLD;
        if (hold)       op = LANE_HOLD;
        else if (clear) op = LANE_CLEAR;
        else if (load)  op = LANE_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            case (op)
                LANE_CLEAR: begin
                    data  <= '0;
                    valid <= 1'b0;
                end
                LANE_LOAD: begin
                    data  <= load_data;
                    valid <= load_valid;
                end
                default: begin
                    data  <= data;
                    valid <= valid;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_idex_multi.sv
// N-lane ID/EX pipeline register with per-lane flush and serial "split" issue
// of a lane-0 instruction across all lanes, one lane per cycle.
module pipe_stage_idex_multi
    import pipe_stage_idex_multi_pkg::*;
#(
    parameter int  STAGE_WIDTH = STAGE_WIDTH_DEFAULT,
    parameter int  LANES       = 2,
    localparam int BEAT_W      = beat_width(LANES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [LANES-1:0]             flush_mask,
    input  logic                         split_req,
    input  logic [LANES-1:0]             in_valid,
    input  logic [LANES*STAGE_WIDTH-1:0] in_data,
    output logic [LANES-1:0]             out_valid,
    output logic [LANES*STAGE_WIDTH-1:0] out_data,
    output logic                         split_stall,
    output logic [BEAT_W-1:0]            split_beat
);

    localparam logic              MULTI     = (LANES > 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

    logic full_flush;
    logic split_active;

    assign full_flush   = flush & (&flush_mask);
    // With a single lane a split degenerates to a normal load.
    assign split_active = split_req & MULTI;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_beat <= '0;
        end else if (stall) begin
            split_beat <= split_beat;
        end else if (full_flush || !split_active || split_beat == LAST_BEAT) begin
            split_beat <= '0;
        end else begin
            split_beat <= split_beat + 1'b1;
        end
    end

    assign split_stall = split_active & (split_beat != LAST_BEAT) & ~full_flush;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic                   sel;
        logic                   clear;
        logic [STAGE_WIDTH-1:0] load_data;
        logic                   load_valid;

        // During a split only the beat-selected lane loads; the rest are cleared.
        assign sel        = (split_beat == BEAT_W'(i));
        assign clear      = (flush & flush_mask[i]) | (split_active & ~sel);
        assign load_data  = split_active ? in_data[0 +: STAGE_WIDTH]
                                         : in_data[i*STAGE_WIDTH +: STAGE_WIDTH];
        assign load_valid = split_active ? in_valid[0] : in_valid[i];

        pipe_lane_reg #(
            .WIDTH (STAGE_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .hold       (stall),
            .clear      (clear),
            .load       (1'b1),
            .load_data  (load_data),
            .load_valid (load_valid),
            .data       (out_data[i*STAGE_WIDTH +: STAGE_WIDTH]),
            .valid      (out_valid[i])
        );
    end

endmodule

// File: tb/tb_pipe_stage_idex_multi.sv
// Scoreboard bench for pipe_stage_idex_multi at LANES=1, 2 and 4.
module tb_pipe_stage_idex_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         stall2, flush2, split2, sst2, beat2;
    logic [1:0]   mask2, inv2, outv2;
    logic [63:0]  ind2, outd2;

    logic         stall4, flush4, split4, sst4;
    logic [1:0]   beat4;
    logic [3:0]   mask4, inv4, outv4;
    logic [127:0] ind4, outd4;

    logic         stall1, flush1, split1, sst1;
    logic [0:0]   beat1, mask1, inv1, outv1;
    logic [7:0]   ind1, outd1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [3:0] v; logic [127:0] d; logic [1:0] b; } exp4_t;
    typedef struct { logic [1:0] v; logic [63:0] d; logic b; } exp2_t;
    exp4_t q4[$];
    exp2_t q2[$];

    pipe_stage_idex_multi #(.STAGE_WIDTH(32), .LANES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall2), .flush(flush2), .flush_mask(mask2),
        .split_req(split2), .in_valid(inv2), .in_data(ind2), .out_valid(outv2),
        .out_data(outd2), .split_stall(sst2), .split_beat(beat2));

    pipe_stage_idex_multi #(.STAGE_WIDTH(32), .LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall4), .flush(flush4), .flush_mask(mask4),
        .split_req(split4), .in_valid(inv4), .in_data(ind4), .out_valid(outv4),
        .out_data(outd4), .split_stall(sst4), .split_beat(beat4));

    pipe_stage_idex_multi #(.STAGE_WIDTH(8), .LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall1), .flush(flush1), .flush_mask(mask1),
        .split_req(split1), .in_valid(inv1), .in_data(ind1), .out_valid(outv1),
        .out_data(outd1), .split_stall(sst1), .split_beat(beat1));

    function automatic logic [127:0] lane4(input int b, input logic [31:0] x);
        logic [127:0] r;
        r = '0;
        r[b*32 +: 32] = x;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall2 = 0; flush2 = 0; split2 = 0; mask2 = '0; inv2 = '0; ind2 = '0;
        stall4 = 0; flush4 = 0; split4 = 0; mask4 = '0; inv4 = '0; ind4 = '0;
        stall1 = 0; flush1 = 0; split1 = 0; mask1 = '0; inv1 = '0; ind1 = '0;
    endtask

    task automatic pop4(input string tag);
        exp4_t e;
        e = q4.pop_front();
        checks += 3;
        if (outv4 !== e.v) begin
            errors++; $display("FAIL %s valid: got %b want %b", tag, outv4, e.v);
        end
        if (outd4 !== e.d) begin
            errors++; $display("FAIL %s data: got %h want %h", tag, outd4, e.d);
        end
        if (beat4 !== e.b) begin
            errors++; $display("FAIL %s beat: got %0d want %0d", tag, beat4, e.b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        checks += 3;
        if ({outv2, outd2, beat2} !== '0) begin
            errors++; $display("FAIL reset2: got %b/%h/%b want 0", outv2, outd2, beat2);
        end
        if ({outv4, outd4, beat4} !== '0) begin
            errors++; $display("FAIL reset4: got %b/%h/%b want 0", outv4, outd4, beat4);
        end
        if ({outv1, outd1, beat1} !== '0) begin
            errors++; $display("FAIL reset1: got %b/%h/%b want 0", outv1, outd1, beat1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        exp2_t e;
        ind2 = {32'hB, 32'hA};
        inv2 = 2'b11;
        q2.push_back('{2'b11, {32'hB, 32'hA}, 1'b0});
        tick();
        e = q2.pop_front();
        checks += 4;
        if (outv2 !== e.v) begin errors++; $display("FAIL pass valid: got %b want %b", outv2, e.v); end
        if (outd2 !== e.d) begin errors++; $display("FAIL pass data: got %h want %h", outd2, e.d); end
        if (beat2 !== e.b) begin errors++; $display("FAIL pass beat: got %b want %b", beat2, e.b); end
        if (sst2 !== 1'b0) begin errors++; $display("FAIL pass split_stall: got %b want 0", sst2); end
        // Asynchronous reset in the middle of a cycle.
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (outv2 !== 2'b00) begin errors++; $display("FAIL async reset valid: got %b want 00", outv2); end
        if (outd2 !== '0) begin errors++; $display("FAIL async reset data: got %h want 0", outd2); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_degenerate();
        split1 = 1; ind1 = 8'h5A; inv1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (sst1 !== 1'b0) begin errors++; $display("FAIL lane1 split_stall: got %b want 0", sst1); end
            tick();
            checks += 3;
            if (outd1 !== 8'h5A) begin errors++; $display("FAIL lane1 data: got %h want 5a", outd1); end
            if (outv1 !== 1'b1) begin errors++; $display("FAIL lane1 valid: got %b want 1", outv1); end
            if (beat1 !== 1'b0) begin errors++; $display("FAIL lane1 beat: got %b want 0", beat1); end
        end
        idle_inputs();
    endtask

    task automatic split_setup();
        split4 = 1;
        inv4   = 4'b1111;
        ind4   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'h00001234};
    endtask

    task automatic split_beat_step(input int b, input string tag);
        q4.push_back('{4'(1 << b), lane4(b, 32'h1234), 2'((b + 1) % 4)});
        #1;
        checks++;
        if (sst4 !== (b != 3)) begin
            errors++; $display("FAIL %s split_stall b%0d: got %b want %b", tag, b, sst4, (b != 3));
        end
        tick();
        pop4(tag);
    endtask

    task automatic test_split();
        split_setup();
        for (int b = 0; b < 4; b++) split_beat_step(b, "split");
        idle_inputs();
    endtask

    task automatic test_stall_mid_split();
        split_setup();
        split_beat_step(0, "stall_pre");
        split_beat_step(1, "stall_pre");
        stall4 = 1;
        for (int k = 0; k < 3; k++) begin
            q4.push_back('{4'b0010, lane4(1, 32'h1234), 2'd2});
            #1;
            checks++;
            if (sst4 !== 1'b1) begin errors++; $display("FAIL stall split_stall: got %b want 1", sst4); end
            tick();
            pop4("stall_hold");
        end
        stall4 = 0;
        split_beat_step(2, "stall_post");
        split_beat_step(3, "stall_post");
        idle_inputs();
    endtask

    task automatic test_partial_flush();
        exp2_t e;
        flush2 = 1; mask2 = 2'b01;
        ind2 = {32'hC, 32'hD}; inv2 = 2'b11;
        q2.push_back('{2'b10, {32'hC, 32'h0}, 1'b0});
        tick();
        e = q2.pop_front();
        checks += 2;
        if (outv2 !== e.v) begin errors++; $display("FAIL pflush valid: got %b want %b", outv2, e.v); end
        if (outd2 !== e.d) begin errors++; $display("FAIL pflush data: got %h want %h", outd2, e.d); end
        idle_inputs();
    endtask

    task automatic test_full_flush_abort();
        split_setup();
        split_beat_step(0, "ffl_pre");
        flush4 = 1; mask4 = 4'hF;
        q4.push_back('{4'b0000, 128'h0, 2'd0});
        #1;
        checks++;
        if (sst4 !== 1'b0) begin errors++; $display("FAIL fflush split_stall: got %b want 0", sst4); end
        tick();
        pop4("fflush");
        // A partial flush of the selected lane clears it but the split still advances.
        mask4 = 4'b0001;
        q4.push_back('{4'b0000, 128'h0, 2'd1});
        #1;
        checks++;
        if (sst4 !== 1'b1) begin errors++; $display("FAIL pflush4 split_stall: got %b want 1", sst4); end
        tick();
        pop4("pflush4");
        flush4 = 0; mask4 = '0;
        split_beat_step(1, "pflush4_next");
        idle_inputs();
        tick();
    endtask

    task automatic test_split_drop();
        split_setup();
        split_beat_step(0, "drop_pre");
        split_beat_step(1, "drop_pre");
        split4 = 0;
        inv4 = 4'b1011;
        ind4 = {32'h4, 32'h3, 32'h2, 32'h1};
        q4.push_back('{4'b1011, {32'h4, 32'h3, 32'h2, 32'h1}, 2'd0});
        #1;
        checks++;
        if (sst4 !== 1'b0) begin errors++; $display("FAIL drop split_stall: got %b want 0", sst4); end
        tick();
        pop4("drop");
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_degenerate();
        test_split();
        test_stall_mid_split();
        test_partial_flush();
        test_full_flush_abort();
        test_split_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
